imm_compress: RTL and testbench
===============================

IMM_COMPRESS -- requirements
Module: imm_compress

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; sampled only on the rising edge of clk.
REQ-004 start  input  1  request; sampled only while idle.
REQ-005 value  input  32  target word to encode; sampled with start.
REQ-006 busy  output  1  high while a request is being processed.
REQ-007 done  output  1  one-cycle completion pulse.
REQ-008 ok  output  1  1 = value is encodable; 0 = no mode fits.
REQ-009 imm  output  16  encoded immediate; valid from done until the next accepted start.
REQ-010 EOp  output  2  selected extension mode; valid from done until the next accepted start.

Function
REQ-011 Extension modes (EOp):
- 0: sign-extend.
- 1: zero-extend.
- 2: imm placed in the upper half, lower half zero.
- 3: {14 sign bits, imm, 2'b00}.
REQ-012 Encode rule: the block SHALL return imm and EOp such that extending imm under EOp reproduces value exactly.
REQ-013 States SHALL be IDLE, TRY and DONE.
- busy = 1 in TRY.
- done = 1 in DONE only.
REQ-014 IDLE with start=1 at an edge:
- latch value;
- set the mode counter to 0;
- go to TRY.
REQ-015 IDLE with start=0: remain in IDLE.
REQ-016 TRY tests exactly one mode per cycle, in the order 0, 1, 2, 3.
REQ-017 TRY, current mode fits, at an edge:
- latch imm and EOp = mode;
- set ok = 1;
- go to DONE.
REQ-018 TRY, current mode fails and mode < 3: increment the mode counter.
REQ-019 TRY, mode 3 fails:
- set ok = 0, imm = 0, EOp = 0;
- go to DONE.
REQ-020 Fit conditions:
- mode 0 fits iff value[31:15] are all equal; imm = value[15:0].
- mode 1 fits iff value[31:16] == 0; imm = value[15:0].
- mode 2 fits iff value[15:0] == 0; imm = value[31:16].
- mode 3 fits iff value[1:0] == 0 and value[31:17] are all equal; imm = value[17:2].
REQ-021 Priority: the lowest-numbered fitting mode SHALL win (for example, 0x00000000 yields EOp = 0).
REQ-022 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-023 Latency: a request that resolves at mode k SHALL raise done in cycle k+2 after the start edge (start edge = edge 0). A failed request raises done in cycle 5.
REQ-024 start asserted in TRY or DONE SHALL be ignored and not queued.
- A new start is accepted in the cycle after done.
REQ-025 value changes after the start edge SHALL NOT affect the result.
REQ-026 imm, EOp and ok SHALL hold their values through IDLE until the next accepted start.

Reset
REQ-027 Reset SHALL force state = IDLE.
REQ-028 Reset SHALL clear busy = 0, done = 0, ok = 0, imm = 0, EOp = 0 and the mode counter = 0.
REQ-029 Reset asserted mid-TRY or in DONE SHALL abort the request with no done pulse.
REQ-030 Reset SHALL take priority over start on the same edge.

Structure
REQ-031 The EOp encodings (the four mode constants) and the FSM state encoding SHALL live in the shared package (ext_pkg).
REQ-032 The combinational fit test SHALL be one sub-module, imm_fit_check.
- Inputs: value[31:0], mode[1:0].
- Outputs: fit, imm[15:0].
REQ-033 imm_compress SHALL contain only the FSM, the mode counter and the output registers.

Verification
REQ-034 value = 0xFFFF8000 -> ok = 1, EOp = 0, imm = 0x8000; done in cycle 2.
REQ-035 value = 0x0000ABCD -> ok = 1, EOp = 1, imm = 0xABCD; done in cycle 3.
REQ-036 value = 0x12340000 -> EOp = 2, imm = 0x1234, done in cycle 4; value = 0x0001FFFC -> EOp = 3, imm = 0x7FFF, done in cycle 5.
REQ-037 value = 0x12345678 -> ok = 0, imm = 0, EOp = 0; done in cycle 5.
REQ-038 start re-asserted with 0x00000001 during TRY of 0x12345678 -> ignored; a single done with ok = 0 results.
REQ-039 Reset asserted in the cycle after start -> no done pulse; all outputs 0; the next start with 0x00000005 returns EOp = 0, imm = 0x0005.

Source files
------------

// File: rtl/ext_pkg.sv
// Shared encodings for the immediate compressor.
// Extension-mode constants and FSM state encoding.
package ext_pkg;

  typedef enum logic [1:0] {
    EOP_SEXT = 2'd0,
    EOP_ZEXT = 2'd1,
    EOP_HI   = 2'd2,
    EOP_SH2  = 2'd3
  } eop_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TRY  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] LAST_MODE = EOP_SH2;

endpackage

// File: rtl/imm_compress_if.sv
// Request/response bundle of the immediate compressor.
// master drives requests, slave returns the encoding.
interface imm_compress_if;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic        ok;
  logic [15:0] imm;
  logic [1:0]  EOp;

  modport master (
    output start, value,
    input  busy, done, ok, imm, EOp
  );

  modport slave (
    input  start, value,
    output busy, done, ok, imm, EOp
  );
endinterface

// File: rtl/imm_fit_check.sv
// Combinational test: does value fit extension mode,
// and which 16-bit immediate would reproduce it.
module imm_fit_check
  import ext_pkg::*;
(
  input  logic [31:0] value,
  input  logic [1:0]  mode,
  output logic        fit,
  output logic [15:0] imm
);

  logic sx_lo;
  logic sx_sh;

  // all-equal upper runs: all ones or all zeros
  assign sx_lo = (&value[31:15]) | ~(|value[31:15]);
  assign sx_sh = (&value[31:17]) | ~(|value[31:17]);

  always_comb begin
    fit = 1'b0;
    imm = 16'h0000;
    unique case (mode)
      EOP_SEXT: begin
        fit = sx_lo;
        imm = value[15:0];
      end
      EOP_ZEXT: begin
        fit = ~(|value[31:16]);
        imm = value[15:0];
      end
      EOP_HI: begin
        fit = ~(|value[15:0]);
        imm = value[31:16];
      end
      EOP_SH2: begin
        fit = ~(|value[1:0]) & sx_sh;
        imm = value[17:2];
      end
      default: begin
        fit = 1'b0;
        imm = 16'h0000;
      end
    endcase
  end

endmodule

// File: rtl/imm_compress.sv
// Sequential search for the lowest extension mode
// that encodes a 32-bit word as a 16-bit immediate.
module imm_compress
  import ext_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  imm_compress_if.slave bus
);

  state_e      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [31:0] val_q, val_d;
  logic        ok_q, ok_d;
  logic [15:0] imm_q, imm_d;
  logic [1:0]  eop_q, eop_d;

  logic        fit;
  logic [15:0] fit_imm;

  imm_fit_check u_fit (
    .value (val_q),
    .mode  (mode_q),
    .fit   (fit),
    .imm   (fit_imm)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= 2'd0;
      val_q   <= 32'h0;
      ok_q    <= 1'b0;
      imm_q   <= 16'h0;
      eop_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      val_q   <= val_d;
      ok_q    <= ok_d;
      imm_q   <= imm_d;
      eop_q   <= eop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    val_d   = val_q;
    ok_d    = ok_q;
    imm_d   = imm_q;
    eop_d   = eop_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          val_d   = bus.value;
          mode_d  = 2'd0;
          state_d = S_TRY;
        end
      end
      S_TRY: begin
        if (fit) begin
          imm_d   = fit_imm;
          eop_d   = mode_q;
          ok_d    = 1'b1;
          state_d = S_DONE;
        end else if (mode_q == LAST_MODE) begin
          imm_d   = 16'h0;
          eop_d   = 2'd0;
          ok_d    = 1'b0;
          state_d = S_DONE;
        end else begin
          mode_d = mode_q + 2'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy = (state_q == S_TRY);
  assign bus.done = (state_q == S_DONE);
  assign bus.ok   = ok_q;
  assign bus.imm  = imm_q;
  assign bus.EOp  = eop_q;

endmodule

// File: tb/tb_imm_compress.sv
// Scoreboard bench for imm_compress: driver queues
// expected results, monitor checks each done pulse.
module tb_imm_compress;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  typedef struct {
    logic        ok;
    logic [1:0]  eop;
    logic [15:0] imm;
    int          lat;
    int          s;
  } exp_t;

  exp_t q[$];

  imm_compress_if bus ();

  imm_compress dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: every done pulse must match the queue head
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.done === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("ok", {31'd0, bus.ok}, {31'd0, e.ok});
        chk("eop", {30'd0, bus.EOp}, {30'd0, e.eop});
        chk("imm", {16'd0, bus.imm}, {16'd0, e.imm});
        chk("latency", cyc - e.s, e.lat);
      end
    end
  end

  task automatic push(input logic ok, input logic [1:0] eop,
                      input logic [15:0] imm, input int lat);
    exp_t e;
    e.ok = ok;
    e.eop = eop;
    e.imm = imm;
    e.lat = lat;
    e.s = cyc;
    q.push_back(e);
  endtask

  task automatic wait_done(output bit seen);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input logic [31:0] v, input logic ok,
                     input logic [1:0] eop,
                     input logic [15:0] imm, input int lat);
    bit seen;
    @(negedge clk);
    push(ok, eop, imm, lat);
    bus.start = 1'b1;
    bus.value = v;
    @(negedge clk);
    bus.start = 1'b0;
    bus.value = $urandom;
    wait_done(seen);
    repeat (3) @(negedge clk);
    chk("hold_ok", {31'd0, bus.ok}, {31'd0, ok});
    chk("hold_eop", {30'd0, bus.EOp}, {30'd0, eop});
    chk("hold_imm", {16'd0, bus.imm}, {16'd0, imm});
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({nm, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({nm, "_ok"}, {31'd0, bus.ok}, 32'd0);
    chk({nm, "_eop"}, {30'd0, bus.EOp}, 32'd0);
    chk({nm, "_imm"}, {16'd0, bus.imm}, 32'd0);
  endtask

  initial begin
    bit seen;
    bus.start = 1'b0;
    bus.value = 32'h0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;

    run(32'hFFFF8000, 1'b1, 2'd0, 16'h8000, 2);
    run(32'h0000ABCD, 1'b1, 2'd1, 16'hABCD, 3);
    run(32'h12340000, 1'b1, 2'd2, 16'h1234, 4);
    run(32'h0001FFFC, 1'b1, 2'd3, 16'h7FFF, 5);
    run(32'h12345678, 1'b0, 2'd0, 16'h0000, 5);
    run(32'h00000000, 1'b1, 2'd0, 16'h0000, 2);
    run(32'hFFFE0000, 1'b1, 2'd2, 16'hFFFE, 4);
    run(32'hFFFE0004, 1'b1, 2'd3, 16'h8001, 5);

    // start re-asserted while busy must be dropped
    @(negedge clk);
    push(1'b0, 2'd0, 16'h0000, 5);
    bus.start = 1'b1;
    bus.value = 32'h12345678;
    @(negedge clk);
    chk("busy_try", {31'd0, bus.busy}, 32'd1);
    bus.value = 32'h00000001;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    wait_done(seen);
    repeat (4) @(negedge clk);
    chk("single_done_q", q.size(), 0);

    // reset in the cycle after start aborts the request
    @(negedge clk);
    bus.start = 1'b1;
    bus.value = 32'hFFFF8000;
    @(negedge clk);
    bus.start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk_zero("abort");
    bus.start = 1'b1;
    bus.value = 32'h0000ABCD;
    @(negedge clk);
    bus.start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_prio_busy", {31'd0, bus.busy}, 32'd0);
    repeat (6) @(negedge clk);
    chk_zero("post_abort");

    run(32'h00000005, 1'b1, 2'd0, 16'h0005, 2);

    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
